// File: rtl/mips150_io_mmio.sv
// MMIO for the MIPS150 load/store path: UART TX buffer, RX FIFO and optional counters (IO_COUNTERS_EN).
// Load data is registered, so it arrives one cycle after io_re. TX stalls via tx_valid/tx_ready; RX is throttled by rx_ready.
module mips150_io_mmio #(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic        io_re,
    input  logic [3:0]  io_we,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        instr_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int AW = $clog2(RX_DEPTH);

    logic [5:0]  idx;
    logic        wr;
    logic [31:0] rd_mux;

    assign idx = io_addr[7:2];
    assign wr  = |io_we;

    // TX: a byte written during a handshake replaces the departing one
    logic tx_full, tx_hs, tx_wr;

    assign tx_hs    = tx_full & tx_ready;
    assign tx_wr    = wr & (idx == 6'd3) & (~tx_full | tx_hs);
    assign tx_valid = tx_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_full <= 1'b0;
            tx_data <= 8'h00;
        end else if (tx_wr) begin
            tx_full <= 1'b1;
            tx_data <= io_wdata[7:0];
        end else if (tx_hs) begin
            tx_full <= 1'b0;
        end
    end

    // RX FIFO: the extra pointer bit separates full from empty
    logic [7:0]  rx_mem [RX_DEPTH];
    logic [AW:0] wp, rp;
    logic        rx_full, rx_empty, rx_push, rx_pop;

    assign rx_empty = (wp == rp);
    assign rx_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & ~rx_full;
    assign rx_pop   = io_re & (idx == 6'd2) & ~rx_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (rx_push) wp <= wp + (AW+1)'(1);
            if (rx_pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[wp[AW-1:0]] <= rx_data;
    end

`ifdef IO_COUNTERS_EN
    logic [31:0] cycle_cnt, instr_cnt;
    logic        cnt_clr;

    assign cnt_clr = wr & (idx == 6'd6);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (cnt_clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_valid) instr_cnt <= instr_cnt + 32'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{io_addr[31:8], io_addr[1:0], io_wdata[31:8]};
`else
    logic unused_bits;
    assign unused_bits = ^{io_addr[31:8], io_addr[1:0], io_wdata[31:8], instr_valid};
`endif

    always_comb begin
        rd_mux = '0;
        case (idx)
            6'd0: rd_mux = {31'b0, ~tx_full};
            6'd1: rd_mux = {31'b0, ~rx_empty};
            6'd2: if (!rx_empty) rd_mux = {24'b0, rx_mem[rp[AW-1:0]]};
`ifdef IO_COUNTERS_EN
            6'd4: rd_mux = cycle_cnt;
            6'd5: rd_mux = instr_cnt;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) io_rdata <= '0;
        else      io_rdata <= io_re ? rd_mux : 32'h0;
    end
endmodule

// File: tb/tb_mips150_io_mmio.sv
// Directed self-checking bench for mips150_io_mmio (RX_DEPTH = 4).
module tb_mips150_io_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] io_addr = '0;
    logic        io_re = 1'b0;
    logic [3:0]  io_we = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        instr_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int checks = 0;
    int errors = 0;

    mips150_io_mmio #(.RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_re(io_re), .io_we(io_we),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .instr_valid(instr_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        io_addr = addr;
        io_re   = 1'b1;
        tick();
        io_re   = 1'b0;
        data    = io_rdata;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
        io_addr  = addr;
        io_we    = we;
        io_wdata = wd;
        tick();
        io_we    = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'hEE;
        tick(); tick(); tick();
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready_in_reset: got %b expected 1", rx_ready); end
        rst = 1'b1;
        rx_valid = 1'b0;
        #1;
        checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", io_rdata); end
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got %b/%h expected 0/00", tx_valid, tx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
        tick();
        do_read(32'h8000_0004, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rx_status: got %h expected 0", d); end
        tick();
        checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL rdata_idle: got %h expected 0", io_rdata); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        tx_ready = 1'b0;
        do_write(32'h8000_000C, 4'b1111, 32'h1234_5641);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_first: got %b/%h expected 1/41", tx_valid, tx_data); end
        do_read(32'h8000_0000, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_status_full: got %h expected 0", d); end
        do_write(32'h8000_000C, 4'b0001, 32'h0000_0042);
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL tx_drop: got %h expected 41", tx_data); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_handshake: got %b expected 0", tx_valid); end
        do_read(32'h8000_0000, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL tx_status_empty: got %h expected 1", d); end
        do_write(32'h8000_000C, 4'b1000, 32'h0000_0050);
        tx_ready = 1'b1;
        do_write(32'h8000_000C, 4'b0100, 32'hFFFF_FF60);
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h60) begin errors++; $display("FAIL tx_replace: got %b/%h expected 1/60", tx_valid, tx_data); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drain: got %b expected 0", tx_valid); end
    endtask

    task automatic test_rx_fill();
        logic [31:0] d;
        logic [7:0]  exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = exp_b[i];
            tick();
        end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready); end
        rx_data = 8'h55;
        tick();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_hold: got %b expected 0", rx_ready); end
        do_read(32'h8000_0004, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rx_status_full: got %h expected 1", d); end
        for (int i = 0; i < 4; i++) begin
            do_read(32'h8000_0008, d);
            checks++; if (d !== {24'h0, exp_b[i]}) begin errors++; $display("FAIL rx_pop%0d: got %h expected %h", i, d, exp_b[i]); end
        end
        do_read(32'h8000_0008, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_pop_empty: got %h expected 0", d); end
        do_read(32'h8000_0004, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_status_empty: got %h expected 0", d); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after: got %b expected 1", rx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tick();
        rx_data  = 8'hAA;
        do_read(32'h8000_0008, d);
        rx_valid = 1'b0;
        checks++; if (d !== 32'h99) begin errors++; $display("FAIL simul_pop: got %h expected 99", d); end
        do_read(32'h8000_0008, d);
        checks++; if (d !== 32'hAA) begin errors++; $display("FAIL simul_next: got %h expected aa", d); end
        do_read(32'h8000_0008, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL simul_empty: got %h expected 0", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        do_read(32'h8000_001C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
        do_write(32'h8000_001C, 4'b1111, 32'h0000_0077);
        checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL unmapped_write: got tx_valid %b rx_ready %b expected 0/1", tx_valid, rx_ready); end
        do_read(32'h8000_0004, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rx: got %h expected 0", d); end
        io_re = 1'b1;
        do_write(32'h8000_000C, 4'b0010, 32'h0000_0033);
        io_re = 1'b0;
        checks++; if (io_rdata !== 32'h0 || tx_valid !== 1'b1 || tx_data !== 8'h33) begin errors++; $display("FAIL re_we: got %h/%b/%h expected 0/1/33", io_rdata, tx_valid, tx_data); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_counters();
        logic [31:0] d;
`ifdef IO_COUNTERS_EN
        do_write(32'h8000_0018, 4'b0001, 32'h0);
        for (int i = 0; i < 100; i++) begin
            instr_valid = (i % 2 == 0);
            tick();
        end
        instr_valid = 1'b0;
        do_read(32'h8000_0010, d);
        checks++; if (d !== 32'd100) begin errors++; $display("FAIL cycle_cnt: got %0d expected 100", d); end
        do_read(32'h8000_0014, d);
        checks++; if (d !== 32'd50) begin errors++; $display("FAIL instr_cnt: got %0d expected 50", d); end
        instr_valid = 1'b1;
        do_write(32'h8000_0018, 4'b1000, 32'h0);
        instr_valid = 1'b0;
        do_read(32'h8000_0010, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL cycle_clr: got %0d expected 0", d); end
        do_read(32'h8000_0014, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL instr_clr: got %0d expected 0", d); end
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cycle_cnt;
        tick();
        do_read(32'h8000_0010, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL cycle_wrap: got %h expected 0", d); end
`else
        instr_valid = 1'b1;
        do_read(32'h8000_0010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL nocnt_cycle: got %h expected 0", d); end
        do_read(32'h8000_0014, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL nocnt_instr: got %h expected 0", d); end
        do_write(32'h8000_0018, 4'b1111, 32'hFFFF_FFFF);
        instr_valid = 1'b0;
        checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL nocnt_clr: got %b/%b expected 0/1", tx_valid, rx_ready); end
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_write(32'h8000_000C, 4'b1111, 32'h0000_00C3);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick(); tick(); tick(); tick();
        rx_valid = 1'b0;
        checks++; if (tx_valid !== 1'b1 || rx_ready !== 1'b0) begin errors++; $display("FAIL pre_reset: got %b/%b expected 1/0", tx_valid, rx_ready); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got %b/%h/%b expected 0/00/1", tx_valid, tx_data, rx_ready); end
        tick();
        rst = 1'b1;
        tick();
        do_read(32'h8000_0004, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_rx_flush: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_fill();
        test_back_to_back();
        test_unmapped();
        test_counters();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips150_io_mmio.md
# mips150_io_mmio

Memory-mapped I/O block sitting on the load/store path of the MIPS150 datapath, in parallel with DMEM. It decodes store and load accesses in the 0x8xxx_xxxx region, buffers one transmit byte toward the UART serializer, queues received bytes in a small FIFO, and exposes cycle and retired-instruction counters. Load data is registered so it arrives in the M stage one cycle after the X-stage request, matching DMEM read latency.

## Interface
Parameters:
- RX_DEPTH, 4, RX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- io_addr  in  32  X-stage effective address; only [7:2] decoded.
- io_re  in  1  X-stage load targeting the I/O region.
- io_we  in  4  X-stage store byte mask; bit 3 = byte 0 (big-endian).
- io_wdata  in  32  store data, unshifted; byte payload is [7:0].
- io_rdata  out  32  M-stage load data.
- instr_valid  in  1  one instruction retired this cycle.
- tx_data  out  8  byte to serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts tx_data.
- rx_data  in  8  byte from deserializer.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block can accept rx_data.

## Operation
- Register map (word offset io_addr[7:0]):
  - 0x00 TX status, read: {31'b0, ~tx_full}.
  - 0x04 RX status, read: {31'b0, ~rx_empty}.
  - 0x08 RX data, read: {24'b0, head}; pops one entry if non-empty; returns 0, no pop, if empty.
  - 0x0C TX data, write (any io_we bit): load io_wdata[7:0] into TX buffer.
  - 0x10 cycle counter, read. 0x14 instruction counter, read.
  - 0x18 counter clear, write (any io_we bit).
  - Other offsets: reads return 0, writes ignored.
- TX buffer: single entry; tx_valid = tx_full; cleared on tx_valid & tx_ready. Write accepted when ~tx_full or handshake in the same cycle (new byte replaces departing one, tx_valid stays 1). Write while full without handshake is dropped.
- RX FIFO: RX_DEPTH entries, pointers wrap modulo RX_DEPTH, extra bit distinguishes full from empty. rx_ready = ~rx_full (registered-state based; no push when full even if popping). Push and pop same cycle on non-empty, non-full FIFO: count unchanged, order preserved.
- Counters (32-bit, wrap 0xFFFF_FFFF -> 0): cycle counter +1 every cycle; instruction counter +1 when instr_valid. Clear write has priority over increment: both read 0 next cycle.
- io_re and io_we both set in one cycle: not legal from datapath; write takes effect, read data still returned.

## Timing
- Reset values: io_rdata 0, tx_valid 0, tx_data 0, rx_ready 1, FIFO empty, counters 0.
- Reset is asynchronous; asserting mid-transfer drops buffered TX byte and all RX entries immediately.
- Load latency 1: io_re in cycle N -> io_rdata valid in N+1; io_rdata is 0 in any cycle following no io_re.
- Status reads reflect state at the cycle-N edge (before that edge's updates).
- TX write in cycle N -> tx_valid = 1 from N+1.
- RX push in cycle N -> RX status reads 1 if io_re occurs in N+1 or later.
- Counter read in N returns value held during N.

## Configuration
- IO_COUNTERS_EN: defined -> cycle/instruction counters and clear register present. Undefined -> counters removed, 0x10/0x14 read 0, 0x18 writes ignored, instr_valid unused.

## Test plan
- Reset with rx_valid=1: after rst rises, io_rdata=0, tx_valid=0, rx_ready=1; first RX status read returns 0 until a push completes.
- SW 0x8000000C data 0x12345641, tx_ready=0 -> tx_valid=1, tx_data=0x41 next cycle; second write 0x42 dropped; tx_ready=1 one cycle -> tx_valid=0; TX status read returns 1.
- Push 0x11,0x22,0x33,0x44 (RX_DEPTH=4) -> rx_ready=0; 0x55 offered not accepted; four reads of 0x08 return 0x11,0x22,0x33,0x44; fifth returns 0; RX status 0.
- Simultaneous push 0xAA and pop with one entry 0x99 -> read returns 0x99, next read 0xAA.
- IO_COUNTERS_EN: run 100 cycles with instr_valid alternating -> counters 100/50 ±read skew; clear write -> both read 0 the cycle after; cycle counter preloaded by force to 0xFFFF_FFFF wraps to 0.
- Read 0x1C and write 0x1C -> io_rdata 0, no state change.
